// File: rtl/unary_ops_pipe.sv
// Elastic pipeline computing one unary/reduction/wildcard operation per transaction,
// with saturating counters for accepted transactions and wildcard matches.
module unary_ops_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_pat,
  input  logic [WIDTH-1:0] in_care,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             clear,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [3:0] OP_NOT   = 4'd0;
  localparam logic [3:0] OP_POS   = 4'd1;
  localparam logic [3:0] OP_NEG   = 4'd2;
  localparam logic [3:0] OP_LNOT  = 4'd3;
  localparam logic [3:0] OP_RAND  = 4'd4;
  localparam logic [3:0] OP_RNAND = 4'd5;
  localparam logic [3:0] OP_ROR   = 4'd6;
  localparam logic [3:0] OP_RNOR  = 4'd7;
  localparam logic [3:0] OP_RXOR  = 4'd8;
  localparam logic [3:0] OP_RXNOR = 4'd9;
  localparam logic [3:0] OP_WEQ   = 4'd10;
  localparam logic [3:0] OP_WNEQ  = 4'd11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] res_d;
  logic             err_d;
  logic             wild_eq;

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [WIDTH-1:0]   dat_q [LATENCY];
  logic [LATENCY-1:0] ld;
  logic               full_tail;
  logic               fire;

  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  // 1-bit results land in bit 0 with the upper bits left at zero.
  always_comb begin
    res_d   = '0;
    err_d   = 1'b0;
    wild_eq = (((in_data ^ in_pat) & in_care) == '0);
    case (in_op)
      OP_NOT:   res_d    = ~in_data;
      OP_POS:   res_d    = in_data;
      OP_NEG:   res_d    = -in_data;
      OP_LNOT:  res_d[0] = (in_data == '0);
      OP_RAND:  res_d[0] = &in_data;
      OP_RNAND: res_d[0] = ~&in_data;
      OP_ROR:   res_d[0] = |in_data;
      OP_RNOR:  res_d[0] = ~|in_data;
      OP_RXOR:  res_d[0] = ^in_data;
      OP_RXNOR: res_d[0] = ~^in_data;
      OP_WEQ:   res_d[0] = wild_eq;
      OP_WNEQ:  res_d[0] = ~wild_eq;
      default:  err_d    = 1'b1;
    endcase
  end

  // A stage may load when out_ready is high or any stage at or after it is empty.
  always_comb begin
    full_tail = 1'b1;
    ld        = '0;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      full_tail = full_tail & vld_q[i];
      ld[i]     = ~full_tail | out_ready;
    end
  end

  assign in_ready = ld[0];
  assign fire     = in_valid & ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      if (ld[0]) begin
        vld_q[0] <= in_valid;
        dat_q[0] <= res_d;
        err_q[0] <= err_d;
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (ld[i]) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];

  always_comb begin
    op_cnt_d    = op_cnt_q;
    match_cnt_d = match_cnt_q;
    if (clear) begin
      op_cnt_d    = '0;
      match_cnt_d = '0;
    end else if (fire) begin
      if (op_cnt_q != CNT_MAX) op_cnt_d = op_cnt_q + 1'b1;
      if (in_op == OP_WEQ && wild_eq && match_cnt_q != CNT_MAX)
        match_cnt_d = match_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q    <= '0;
      match_cnt_q <= '0;
    end else begin
      op_cnt_q    <= op_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign op_count    = op_cnt_q;
  assign match_count = match_cnt_q;

endmodule

// File: tb/tb_unary_ops_pipe.sv
// Directed bench for unary_ops_pipe (WIDTH=4, LATENCY=2, CNT_W=2) with a
// queue-based reference model checked every cycle.
module tb_unary_ops_pipe;
  localparam int W    = 4;
  localparam int LAT  = 2;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_data, in_pat, in_care;
  logic [3:0]    in_op;
  logic          out_valid, out_ready, out_err;
  logic [W-1:0]  out_data;
  logic          clear;
  logic [CW-1:0] op_count, match_count;

  unary_ops_pipe #(.WIDTH(W), .LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_pat(in_pat), .in_care(in_care),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .clear(clear), .op_count(op_count),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int c; logic [3:0] d; logic e; } log_t;
  logic [4:0] q[$];
  log_t       lg[$];
  int         m_op = 0, m_match = 0;
  logic       hold_v = 1'b0;
  logic [3:0] hold_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result {err, data} derived from the opcode definitions with plain arithmetic.
  function automatic logic [4:0] model(input logic [3:0] op, input logic [3:0] d,
                                        input logic [3:0] p, input logic [3:0] c);
    int v;
    v = int'(d);
    case (op)
      4'd0:    return {1'b0, 4'(15 - v)};
      4'd1:    return {1'b0, d};
      4'd2:    return {1'b0, 4'((16 - v) % 16)};
      4'd3:    return 5'(v == 0);
      4'd4:    return 5'(v == 15);
      4'd5:    return 5'(v != 15);
      4'd6:    return 5'(v != 0);
      4'd7:    return 5'(v == 0);
      4'd8:    return 5'($countones(d) % 2);
      4'd9:    return 5'(1 - ($countones(d) % 2));
      4'd10:   return 5'(((d ^ p) & c) == 4'd0);
      4'd11:   return 5'(((d ^ p) & c) != 4'd0);
      default: return 5'b10000;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [4:0] e, r;
    if (!rst_n) begin
      q.delete();
      m_op = 0; m_match = 0; hold_v = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_match_count", match_count, 0);
    end else begin
      chk("in_ready", in_ready, (q.size() < LAT) || out_ready);
      chk("op_count", op_count, m_op);
      chk("match_count", match_count, m_match);
      if (hold_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_out: data %0h with nothing outstanding", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e[3:0]);
          chk("out_err", out_err, e[4]);
        end
        lg.push_back('{cyc, out_data, out_err});
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      r = model(in_op, in_data, in_pat, in_care);
      if (in_valid && in_ready) q.push_back(r);
      if (clear) begin
        m_op = 0; m_match = 0;
      end else if (in_valid && in_ready) begin
        if (m_op < MAXC) m_op++;
        if (in_op == 4'd10 && r[0] && m_match < MAXC) m_match++;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [3:0] d,
                      input logic [3:0] p, input logic [3:0] c);
    int b = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_pat = p; in_care = c;
    @(negedge clk);
    while (!in_ready && b < 50) begin @(negedge clk); b++; end
    if (b >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int b = 0;
    in_valid = 1'b0;
    step();
    while ((q.size() != 0 || out_valid) && b < 60) begin step(); b++; end
    if (b >= 60) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int i, input logic [3:0] d, input logic e);
    if (i >= lg.size()) begin
      n_tests++; n_fail++;
      $display("FAIL %s: only %0d results logged, required entry %0d", nm, lg.size(), i);
    end else begin
      chk({nm, "_data"}, lg[i].d, d);
      chk({nm, "_err"}, lg[i].e, e);
    end
  endtask

  initial begin
    int t0, idx;
    logic acc;
    logic [3:0] bp_ops [3];
    bp_ops = '{4'd0, 4'd1, 4'd2};
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0; in_pat = '0;
    in_care = '0; out_ready = 1'b1; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_op_count", op_count, 0);
    step();

    // Back-to-back latency check
    lg.delete(); t0 = cyc;
    send(4'd2, 4'b0000, 4'd0, 4'd0);
    send(4'd3, 4'b0000, 4'd0, 4'd0);
    send(4'd5, 4'b0000, 4'd0, 4'd0);
    drain();
    chk("lat_count", lg.size(), 3);
    chk_log("lat0", 0, 4'b0000, 1'b0);
    chk_log("lat1", 1, 4'b0001, 1'b0);
    chk_log("lat2", 2, 4'b0001, 1'b0);
    if (lg.size() == 3) begin
      chk("lat0_cycle", lg[0].c, t0 + 2);
      chk("lat1_cycle", lg[1].c, t0 + 3);
      chk("lat2_cycle", lg[2].c, t0 + 4);
    end

    lg.delete();
    send(4'd2, 4'b0001, 4'd0, 4'd0);
    send(4'd0, 4'b1010, 4'd0, 4'd0);
    send(4'd8, 4'b0111, 4'd0, 4'd0);
    send(4'd9, 4'b0111, 4'd0, 4'd0);
    drain();
    chk_log("neg_wrap", 0, 4'b1111, 1'b0);
    chk_log("not", 1, 4'b0101, 1'b0);
    chk_log("rxor", 2, 4'b0001, 1'b0);
    chk_log("rxnor", 3, 4'b0000, 1'b0);

    lg.delete();
    pulse_clear();
    send(4'd10, 4'b0110, 4'b1010, 4'b0011);
    send(4'd11, 4'b0110, 4'b1010, 4'b0011);
    in_valid = 1'b0;
    @(negedge clk);
    chk("wild_match_count", match_count, 1);
    chk("wild_op_count", op_count, 2);
    step();
    send(4'd10, 4'b0110, 4'b1010, 4'b1111);
    send(4'd10, 4'b1001, 4'b0110, 4'b0000);
    drain();
    chk_log("wildeq", 0, 4'b0001, 1'b0);
    chk_log("wildneq", 1, 4'b0000, 1'b0);
    chk_log("wildeq_fullcare", 2, 4'b0000, 1'b0);
    chk_log("wildeq_nocare", 3, 4'b0001, 1'b0);

    // Backpressure: capacity is LAT entries
    lg.delete(); out_ready = 1'b0; idx = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_op = bp_ops[idx]; in_data = 4'b0011;
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    step();
    out_ready = 1'b1;
    send(4'd2, 4'b0011, 4'd0, 4'd0);
    drain();
    chk("bp_count", lg.size(), 3);
    chk_log("bp0", 0, 4'b1100, 1'b0);
    chk_log("bp1", 1, 4'b0011, 1'b0);
    chk_log("bp2", 2, 4'b1101, 1'b0);

    lg.delete();
    pulse_clear();
    send(4'hF, 4'b1111, 4'd0, 4'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_op_count", op_count, 1);
    drain();
    chk_log("illegal", 0, 4'b0000, 1'b1);

    pulse_clear();
    for (int k = 0; k < 5; k++) send(4'(k), 4'(k + 3), 4'd0, 4'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_op_count", op_count, 3);
    step();
    clear = 1'b1;
    send(4'd1, 4'b0101, 4'd0, 4'd0);
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clear_wins", op_count, 0);
    drain();

    // Reset in the middle of a stalled stream
    out_ready = 1'b0;
    send(4'd10, 4'b0000, 4'd0, 4'd0);
    send(4'd1, 4'b1001, 4'd0, 4'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", out_valid, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_match_count", match_count, 0);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    step();
    lg.delete();
    send(4'd6, 4'b0100, 4'd0, 4'd0);
    drain();
    chk("post_rst_count", lg.size(), 1);
    chk_log("post_rst", 0, 4'b0001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
